fifo_rd_unpacker: RTL and testbench

- Downstream consumer of the team's synchronous FIFO. Sits between the FIFO read side and a narrow valid/ready datapath stage.
- Drives the FIFO read-request handshake and captures each wide word one cycle after the request.
- Buffers up to two words and emits each word as RATIO narrow beats, LSB slice first, under backpressure.

---
 rtl/fifo_rd_unpacker.sv | 79 +++++++
 tb/tb_fifo_rd_unpacker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_unpacker.sv
// FIFO read-side unpacker: prefetches wide words into a 2-deep buffer
// and streams each one out as RATIO narrow beats, LSB slice first.
module fifo_rd_unpacker #(
   parameter int DATA_WIDTH = 64,
   parameter int OUT_WIDTH  = 16,
   parameter int RATIO      = DATA_WIDTH / OUT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_read_ready,
   output logic                  fifo_read_req,
   input  logic [DATA_WIDTH-1:0] fifo_read_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_last,
   output logic                  busy
);

   localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

   logic [DATA_WIDTH-1:0] slot [2];
   logic [DATA_WIDTH-1:0] cur;
   logic [1:0]            occ;
   logic                  inflight;
   logic [IW-1:0]         idx;
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic                  at_last;
   logic                  xfer;
   logic                  pop_now;
   logic [2:0]            level;

   assign at_last = (idx == LAST_IDX);
   assign m_valid = (occ != 2'd0);
   assign xfer    = m_valid & m_ready;
   assign pop_now = xfer & at_last;

   // Occupancy after this edge; requesting only while it stays below two
   // means a capture can never land on a full buffer.
   assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop_now};

   assign fifo_read_req = reset & fifo_read_ready & (level < 3'd2);

   assign cur    = slot[rd_ptr];
   assign m_data = cur[int'(idx) * OUT_WIDTH +: OUT_WIDTH];
   assign m_last = m_valid & at_last;
   assign busy   = m_valid | inflight;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         idx      <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            slot[i] <= '0;
         end
      end else begin
         inflight <= fifo_read_req;
         occ      <= level[1:0];
         if (inflight) begin
            slot[wr_ptr] <= fifo_read_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (xfer) begin
            if (at_last) begin
               idx    <= '0;
               rd_ptr <= ~rd_ptr;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Directed bench for fifo_rd_unpacker: a 4:1 build and a 1:1 build,
// each fed by a small behavioural FIFO with registered read data.
module tb_fifo_rd_unpacker;

   logic        clk = 1'b0;
   logic        reset;
   logic        rdy, req, m_valid, m_ready, m_last, busy;
   logic [63:0] rdata;
   logic [15:0] m_data;
   logic        rdy2, req2, m_valid2, m_ready2, m_last2, busy2;
   logic [63:0] rdata2;
   logic [63:0] m_data2;

   int checks   = 0;
   int failures = 0;
   int head  = 0, tail  = 0;
   int head2 = 0, tail2 = 0;
   logic [63:0] mem  [64];
   logic [63:0] mem2 [64];

   always #5 clk = ~clk;

   fifo_rd_unpacker #(.DATA_WIDTH(64), .OUT_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .fifo_read_ready(rdy), .fifo_read_req(req),
      .fifo_read_data(rdata),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .busy(busy)
   );

   fifo_rd_unpacker #(.DATA_WIDTH(64), .OUT_WIDTH(64)) dut1 (
      .clk(clk), .reset(reset),
      .fifo_read_ready(rdy2), .fifo_read_req(req2),
      .fifo_read_data(rdata2),
      .m_valid(m_valid2), .m_ready(m_ready2),
      .m_data(m_data2), .m_last(m_last2), .busy(busy2)
   );

   assign rdy  = (head != tail);
   assign rdy2 = (head2 != tail2);

   always @(posedge clk) begin
      if (req) begin
         rdata <= mem[head];
         head  <= head + 1;
      end
      if (req2) begin
         rdata2 <= mem2[head2];
         head2  <= head2 + 1;
      end
   end

   function automatic logic [15:0] sl(input int w, input int k);
      return 16'(w * 256 + k + 1);
   endfunction

   function automatic logic [63:0] mk(input int w);
      logic [63:0] r;
      for (int k = 0; k < 4; k++) r[k*16 +: 16] = sl(w, k);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int w);
      mem[tail] = mk(w);
      tail++;
   endtask

   task automatic run(input int w0, input int n, input int budget,
                      input bit tog, input int out0,
                      output int nreq, output int span, output int maxout);
      int nb    = 0;
      int first = -1;
      int out   = out0;
      nreq   = 0;
      span   = -1;
      maxout = out0;
      for (int c = 0; c < budget && nb < n; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            check("beat_data", 64'(m_data), 64'(sl(w0 + nb / 4, nb % 4)));
            check("beat_last", 64'(m_last), 64'(nb % 4 == 3));
            if (first < 0) first = c;
            span = c - first;
            if (nb % 4 == 3) out--;
            nb++;
         end
         if (req) begin
            nreq++;
            out++;
         end
         if (out > maxout) maxout = out;
         cyc();
         if (tog) m_ready = ~m_ready;
      end
      check("beat_count", 64'(nb), 64'(n));
   endtask

   initial begin
      int nreq, span, mx, nb;
      reset    = 1'b0;
      m_ready  = 1'b1;
      m_ready2 = 1'b1;
      repeat (2) cyc();

      // reset state
      @(negedge clk);
      check("rst_req", 64'(req), 64'd0);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_data", 64'(m_data), 64'd0);
      check("rst_last", 64'(m_last), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_busy1", 64'(busy2), 64'd0);
      cyc();
      reset = 1'b1;

      // single word latency and beat order
      push(0);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         check("t1_req", 64'(req), 64'(c == 0));
         check("t1_valid", 64'(m_valid), 64'(c >= 2 && c <= 5));
         if (m_valid) begin
            check("t1_data", 64'(m_data), 64'(c - 1));
            check("t1_last", 64'(m_last), 64'(c == 5));
         end
         check("t1_busy", 64'(busy), 64'(c >= 1 && c <= 5));
         cyc();
      end

      // four words streamed without gaps
      for (int w = 1; w <= 4; w++) push(w);
      run(1, 16, 40, 1'b0, 0, nreq, span, mx);
      check("t2_reqs", 64'(nreq), 64'd4);
      check("t2_span", 64'(span), 64'd15);

      // backpressure stops prefetch at two words
      m_ready = 1'b0;
      for (int w = 5; w <= 7; w++) push(w);
      nreq = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (req) nreq++;
         cyc();
      end
      @(negedge clk);
      check("t3_reqs", 64'(nreq), 64'd2);
      check("t3_req_now", 64'(req), 64'd0);
      check("t3_valid", 64'(m_valid), 64'd1);
      check("t3_hold", 64'(m_data), 64'(sl(5, 0)));
      check("t3_last", 64'(m_last), 64'd0);
      cyc();
      m_ready = 1'b1;
      run(5, 12, 40, 1'b0, 2, nreq, span, mx);
      check("t3_reqs_rel", 64'(nreq), 64'd1);

      // m_ready toggling every cycle
      for (int w = 8; w <= 13; w++) push(w);
      run(8, 24, 100, 1'b1, 0, nreq, span, mx);
      check("t4_reqs", 64'(nreq), 64'd6);
      check("t4_credit", 64'(mx <= 2), 64'd1);
      m_ready = 1'b1;
      repeat (3) cyc();
      @(negedge clk);
      check("t4_drained", 64'(m_valid), 64'd0);
      check("t4_idle", 64'(busy), 64'd0);

      // asynchronous reset in the middle of a word
      cyc();
      m_ready = 1'b0;
      for (int w = 14; w <= 16; w++) push(w);
      repeat (6) cyc();
      m_ready = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      check("t5_pre", 64'(m_data), 64'(sl(14, 2)));
      reset = 1'b0;
      #1;
      check("t5_req", 64'(req), 64'd0);
      check("t5_valid", 64'(m_valid), 64'd0);
      check("t5_data", 64'(m_data), 64'd0);
      check("t5_last", 64'(m_last), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      cyc();
      cyc();
      reset = 1'b1;
      run(16, 4, 20, 1'b0, 0, nreq, span, mx);
      check("t5_reqs", 64'(nreq), 64'd1);

      // 1:1 build, one word per cycle
      for (int w = 20; w < 28; w++) begin
         mem2[tail2] = mk(w);
         tail2++;
      end
      nb = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c < 8) check("t6_req", 64'(req2), 64'd1);
         check("t6_valid", 64'(m_valid2), 64'(c >= 2 && c <= 9));
         if (m_valid2) begin
            check("t6_data", m_data2, mk(20 + nb));
            check("t6_last", 64'(m_last2), 64'd1);
            nb++;
         end
         cyc();
      end
      check("t6_count", 64'(nb), 64'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
